// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// sequencing each transaction over a req/ack handshake and generating pipeline stalls.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   discard;
    logic   dm_req;
    logic   dm_grant;
    logic   if_grant;
    logic   ack_if;
    logic   ack_dm;
    logic   drop_fetch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_grant) begin
                    state_nxt = DM_BUSY;
                end else if (if_grant) begin
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A requester whose done is high this cycle is presenting a stale request.
    always_comb begin
        dm_req     = dm_rd | dm_wr;
        dm_grant   = (state == IDLE) && dm_req && !dm_done;
        if_grant   = (state == IDLE) && !dm_grant && if_req && !if_done && !if_flush;
        ack_if     = (state == IF_BUSY) && mem_ack;
        ack_dm     = (state == DM_BUSY) && mem_ack;
        drop_fetch = discard | if_flush;
        stall_if   = if_req & ~if_done;
        stall_mem  = dm_req & ~dm_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_done   <= 1'b0;
            discard   <= 1'b0;
        end else begin
            if_done <= ack_if & ~drop_fetch;
            dm_done <= ack_dm;

            if (dm_grant) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_wr;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (if_grant) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (ack_if || ack_dm) begin
                mem_req <= 1'b0;
            end

            if (ack_if && !drop_fetch) begin
                if_rdata <= mem_rdata;
            end
            if (ack_dm && !mem_we) begin
                dm_rdata <= mem_rdata;
            end

            // A flush seen in the ack cycle itself is folded in via drop_fetch.
            if (ack_if) begin
                discard <= 1'b0;
            end else if ((state == IF_BUSY) && if_flush) begin
                discard <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed handshake cases, then randomized fetch/load/store
// traffic checked against a transaction-level model and a reference memory image.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // phys is what the memory responder holds; model is the program-order image.
    logic [31:0] phys  [logic [31:0]];
    logic [31:0] model [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : init_word(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model.exists(a) ? model[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rand_fetch();
        return 32'h100 + 4 * $urandom_range(0, 15);
    endfunction

    task automatic new_dm_op();
        int unsigned k = $urandom_range(0, 9);
        dm_addr  = 32'h2000 + 4 * $urandom_range(0, 7);
        dm_wdata = $urandom;
        dm_wr    = (k < 4) || (k == 9);
        dm_rd    = (k >= 4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected transaction and per-cycle snapshot of what the DUT sampled.
    bit          e_req, t_if, t_we, flush_seen;
    logic [31:0] t_addr, t_wdata;
    bit          e_if_done, e_dm_done, adv_if, adv_dm;
    logic [31:0] e_if_rdata, e_dm_rdata;
    bit          p_ack, p_dm_elig, p_if_elig, p_dm_wr;
    logic [31:0] p_dm_addr, p_dm_wdata, p_if_addr;
    int unsigned lat;
    logic [31:0] pc;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_dm_done", 32'(dm_done), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single fetch, ack on the third cycle of mem_req.
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("f_mem_req", 32'(mem_req), 32'd1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_we", 32'(mem_we), 32'd0);
        check("f_stall_if", 32'(stall_if), 32'd1);
        repeat (2) tick();
        check("f_mem_req_held", 32'(mem_req), 32'd1);
        check("f_no_early_done", 32'(if_done), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        check("f_if_done", 32'(if_done), 32'd1);
        check("f_if_rdata", if_rdata, 32'h00500093);
        check("f_mem_req_drop", 32'(mem_req), 32'd0);
        check("f_stall_if_done", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();
        check("f_if_done_pulse", 32'(if_done), 32'd0);
        check("f_if_rdata_hold", if_rdata, 32'h00500093);

        // Store with immediate ack; dm_rdata must not move.
        dm_wr = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF;
        tick();
        check("s_mem_we", 32'(mem_we), 32'd1);
        check("s_mem_addr", mem_addr, 32'h2004);
        check("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check("s_dm_done", 32'(dm_done), 32'd1);
        check("s_dm_rdata", dm_rdata, 32'd0);
        check("s_stall_mem", 32'(stall_mem), 32'd0);
        dm_wr = 1'b0;
        tick();
        check("s_dm_done_pulse", 32'(dm_done), 32'd0);

        // Reset while a load is outstanding.
        dm_rd = 1'b1; dm_addr = 32'h3000;
        tick();
        check("r_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r_mem_req_async", 32'(mem_req), 32'd0);
        check("r_mem_addr_async", mem_addr, 32'd0);
        check("r_if_rdata_async", if_rdata, 32'd0);
        dm_rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("r_mem_req_after", 32'(mem_req), 32'd0);
        check("r_dm_done_after", 32'(dm_done), 32'd0);

        // Randomized traffic.
        e_req = 0; t_if = 0; t_we = 0; flush_seen = 0; t_addr = '0; t_wdata = '0;
        e_if_done = 0; e_dm_done = 0; adv_if = 0; adv_dm = 0;
        e_if_rdata = '0; e_dm_rdata = '0;
        p_ack = 0; p_dm_elig = 0; p_if_elig = 0; p_dm_wr = 0;
        p_dm_addr = '0; p_dm_wdata = '0; p_if_addr = '0;
        lat = $urandom_range(0, 3);
        pc = 32'h100;
        phys.delete();
        model.delete();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            // Requesters advance in the cycle after their done.
            if (adv_if) begin
                adv_if = 0;
                if ($urandom_range(0, 3) != 0) begin
                    pc = 32'h100 + ((pc - 32'h100 + 32'd4) & 32'h3C);
                    if_addr = pc;
                    if_req = 1'b1;
                end else begin
                    if_req = 1'b0;
                end
            end
            if (adv_dm) begin
                adv_dm = 0;
                if ($urandom_range(0, 1) != 0) new_dm_op();
                else begin dm_rd = 1'b0; dm_wr = 1'b0; end
            end

            e_if_done = 0;
            e_dm_done = 0;
            if (e_req) begin
                if (p_ack) begin
                    e_req = 0;
                    if (t_if) begin
                        if (!flush_seen) begin
                            e_if_done = 1;
                            e_if_rdata = model_rd(t_addr);
                        end
                    end else begin
                        e_dm_done = 1;
                        if (t_we) model[t_addr] = t_wdata;
                        else e_dm_rdata = model_rd(t_addr);
                    end
                end
            end else if (p_dm_elig) begin
                e_req = 1; t_if = 0; t_we = p_dm_wr; t_addr = p_dm_addr; t_wdata = p_dm_wdata;
            end else if (p_if_elig) begin
                e_req = 1; t_if = 1; t_we = 0; t_addr = p_if_addr; flush_seen = 0;
            end

            check("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                check("mem_addr", mem_addr, t_addr);
                check("mem_we", 32'(mem_we), 32'(t_we));
                if (t_we) check("mem_wdata", mem_wdata, t_wdata);
            end
            check("if_done", 32'(if_done), 32'(e_if_done));
            check("dm_done", 32'(dm_done), 32'(e_dm_done));
            check("if_rdata", if_rdata, e_if_rdata);
            check("dm_rdata", dm_rdata, e_dm_rdata);
            adv_if = e_if_done;
            adv_dm = e_dm_done;

            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = pc;
            end
            if (!dm_rd && !dm_wr && $urandom_range(0, 3) == 0) new_dm_op();
            if_flush = 1'b0;
            if (if_req && !e_if_done && $urandom_range(0, 9) == 0) begin
                if_flush = 1'b1;
                pc = rand_fetch();
                if_addr = pc;
            end

            // Memory responder: random latency, occasional stray ack while idle.
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (lat == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) phys[mem_addr] = mem_wdata;
                    else mem_rdata = phys_rd(mem_addr);
                    lat = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
            end

            p_ack = mem_ack;
            if (e_req && t_if && if_flush) flush_seen = 1;
            p_dm_elig  = (dm_rd || dm_wr) && !e_dm_done;
            p_dm_wr    = dm_wr;
            p_dm_addr  = dm_addr;
            p_dm_wdata = dm_wdata;
            p_if_elig  = if_req && !e_if_done && !if_flush;
            p_if_addr  = if_addr;

            #1;
            check("stall_if", 32'(stall_if), 32'(if_req && !e_if_done));
            check("stall_mem", 32'(stall_mem), 32'((dm_rd || dm_wr) && !e_dm_done));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
